// File: rtl/fetch_queue.sv
// fetch_queue: in-order bundle FIFO between fetch and decode with flush and stall back-pressure.
// Optional same-cycle empty-queue bypass under FETCH_QUEUE_BYPASS_EN.
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 2
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 16
`endif
module fetch_queue #(
    parameter int FETCH_WIDTH     = `FETCH_WIDTH,
    parameter int INST_ADDR_WIDTH = `INST_ADDR_WIDTH,
    parameter int DEPTH           = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    input  logic [32*FETCH_WIDTH-1:0]     in_inst,
    input  logic [INST_ADDR_WIDTH-1:0]    in_pc,
    output logic                          stall_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [32*FETCH_WIDTH-1:0]     out_inst,
    output logic [INST_ADDR_WIDTH-1:0]    out_pc,
    output logic [INST_ADDR_WIDTH-1:0]    out_pc_plus_4,
    output logic [$clog2(DEPTH+1)-1:0]    count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = 32*FETCH_WIDTH;
    logic [IW-1:0]              mem_inst [DEPTH];
    logic [INST_ADDR_WIDTH-1:0] mem_pc   [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic full, empty, byp, push, pop;
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
`ifdef FETCH_QUEUE_BYPASS_EN
    assign byp = empty & in_valid & ~flush;
`else
    assign byp = 1'b0;
`endif
    // A bypassed bundle taken by decode this cycle is never written.
    assign push = in_valid & ~full & ~flush & ~(byp & out_ready);
    assign pop  = ~empty & out_ready & ~flush;
    always_comb begin
        stall_out     = full;
        out_valid     = ~empty | byp;
        out_inst      = byp ? in_inst : empty ? '0 : mem_inst[rd_ptr];
        out_pc        = byp ? in_pc : empty ? '0 : mem_pc[rd_ptr];
        out_pc_plus_4 = out_pc + INST_ADDR_WIDTH'(4);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[wr_ptr] <= in_inst;
            mem_pc[wr_ptr]   <= in_pc;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios plus random traffic checked against a queue-based model.
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 2
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 16
`endif
module tb_fetch_queue;
    localparam int FW = `FETCH_WIDTH;
    localparam int PW = `INST_ADDR_WIDTH;
    localparam int DEPTH = 4;
    localparam int IW = 32*FW;
    localparam int CW = $clog2(DEPTH+1);
    localparam int KW = IW + PW;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic [IW-1:0] in_inst = '0, out_inst;
    logic [PW-1:0] in_pc = '0, out_pc, out_pc_plus_4;
    logic stall_out, out_valid;
    logic [CW-1:0] count;
    int checks = 0, failures = 0;
    typedef struct { logic [IW-1:0] inst; logic [PW-1:0] pc; } ent_t;
    ent_t q[$];

    fetch_queue #(.FETCH_WIDTH(FW), .INST_ADDR_WIDTH(PW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_inst(in_inst),
        .in_pc(in_pc), .stall_out(stall_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc), .out_pc_plus_4(out_pc_plus_4), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [KW-1:0] got, input logic [KW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [IW-1:0] rand_inst();
        logic [IW-1:0] r;
        for (int i = 0; i < FW; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Compare outputs against the model, then advance one clock and update the model.
    task automatic cycle();
        logic byp, ev;
        logic [IW-1:0] ei;
        logic [PW-1:0] ep, e4;
        int sz;
        sz  = q.size();
        byp = BYP && sz == 0 && in_valid && !flush;
        ev  = byp || sz > 0;
        ei  = byp ? in_inst : sz > 0 ? q[0].inst : '0;
        ep  = byp ? in_pc : sz > 0 ? q[0].pc : '0;
        e4  = ep + PW'(4);
        chk("out_valid", KW'(out_valid), KW'(ev));
        chk("out_inst", KW'(out_inst), KW'(ei));
        chk("out_pc", KW'(out_pc), KW'(ep));
        chk("out_pc_plus_4", KW'(out_pc_plus_4), KW'(e4));
        chk("count", KW'(count), KW'(sz));
        chk("stall_out", KW'(stall_out), KW'(sz == DEPTH));
        @(posedge clk);
        if (flush) q.delete();
        else begin
            if (ev && out_ready && !byp) void'(q.pop_front());
            if (in_valid && sz < DEPTH && !(byp && out_ready)) q.push_back('{in_inst, in_pc});
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic rdy, input logic fl, input logic [PW-1:0] pc);
        in_valid  = v;
        out_ready = rdy;
        flush     = fl;
        in_pc     = pc;
        in_inst   = rand_inst();
        cycle();
    endtask

    logic [PW-1:0] prev_pc;

    initial begin
        #12 reset = 0;
        chk("rst_valid", KW'(out_valid), KW'(0));
        chk("rst_pc4", KW'(out_pc_plus_4), KW'(4));
        chk("rst_count", KW'(count), KW'(0));
        @(posedge clk); #1;
        // Async reset mid-traffic
        for (int i = 0; i < 3; i++) drive(1, 0, 0, PW'(4*i));
        chk("pre_rst_count", KW'(count), KW'(3));
        in_valid = 0;
        #2 reset = 1;
        #1;
        q.delete();
        chk("midrst_valid", KW'(out_valid), KW'(0));
        chk("midrst_count", KW'(count), KW'(0));
        chk("midrst_stall", KW'(stall_out), KW'(0));
        chk("midrst_pc", KW'(out_pc), KW'(0));
        #1 reset = 0;
        drive(1, 0, 0, PW'('h40));
        chk("post_rst_pc", KW'(out_pc), KW'('h40));
        drive(0, 1, 0, 0);
        // Fill, drop fifth, drain in order
        for (int i = 0; i < DEPTH; i++) drive(1, 0, 0, PW'(4*i));
        chk("full_stall", KW'(stall_out), KW'(1));
        drive(1, 0, 0, PW'(16));
        chk("full_count", KW'(count), KW'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_pc", KW'(out_pc), KW'(4*i));
            drive(0, 1, 0, 0);
        end
        chk("drained", KW'(out_valid), KW'(0));
        // Continuous push+pop across pointer wrap
        drive(1, 0, 0, PW'(0));
        for (int i = 1; i <= 10; i++) begin
            prev_pc = out_pc;
            drive(1, 1, 0, PW'(4*FW*i));
            chk("stream_count", KW'(count), KW'(1));
            chk("stream_step", KW'(PW'(out_pc - prev_pc)), KW'(4*FW));
        end
        drive(0, 1, 0, 0);
        // Flush with simultaneous push and pop
        drive(1, 0, 0, PW'('h100));
        drive(1, 0, 0, PW'('h104));
        drive(1, 1, 1, PW'('h108));
        chk("flush_count", KW'(count), KW'(0));
        chk("flush_valid", KW'(out_valid), KW'(0));
        // Hold stability and pc+4 wrap
        drive(1, 0, 0, PW'('hFFFC));
        for (int i = 0; i < 5; i++) begin
            chk("hold_pc", KW'(out_pc), KW'('hFFFC));
            chk("hold_pc4", KW'(out_pc_plus_4), KW'(PW'('hFFFC + 4)));
            drive(0, 0, 0, 0);
        end
        drive(0, 1, 0, 0);
        // Empty queue: bypass vs one-cycle latency
        in_valid = 1; out_ready = 1; in_pc = PW'('h200); in_inst = rand_inst();
        #1;
        chk("byp_valid", KW'(out_valid), KW'(BYP));
        cycle();
        chk("byp_count", KW'(count), KW'(BYP ? 0 : 1));
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        // Random traffic
        for (int i = 0; i < 400; i++)
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 19) == 0), PW'($urandom));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
